// File: rtl/bhv_basic_computer_core_if.sv
// Memory bus between the core and its external single-port memory.
// Reads are combinational; a write commits at the rising edge when mem_we is high.
interface bhv_basic_computer_core_if #(
    parameter int WIDTH = 16,
    parameter int AW    = WIDTH - 4
);
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_we;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/bhv_basic_computer_core.sv
// Mano-style basic computer core: fetch/decode/execute sequenced by SC (T0..T6),
// memory/register/I-O instruction groups, interrupt cycle, HLT/start and FGI/FGO flags.
module bhv_basic_computer_core #(
    parameter int WIDTH    = 16,
    parameter int RESET_PC = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      irq,
    bhv_basic_computer_core_if.master bus,
    input  logic [7:0]                in_data,
    input  logic                      in_strobe,
    output logic                      in_ready,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ack,
    output logic [WIDTH-1:0]          ac,
    output logic [WIDTH-5:0]          pc,
    output logic                      e,
    output logic                      ien,
    output logic                      halted
);
    localparam int AW = WIDTH - 4;
    localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} tStep;

    tStep             sc, scN;
    logic [AW-1:0]    ar, arN, pcReg, pcN, pcInc;
    logic [WIDTH-1:0] ir, irN, acReg, acN, dr, drN, tr, trN;
    logic             eReg, eN, iBit, iN, rFlag, rN, ienReg, ienN, sFlag, sN;
    logic             fgi, fgiN, fgo, fgoN;
    logic [7:0]       inpr, inprN, outr, outrN;
    logic             memWe, inpExec, outExec;
    logic [WIDTH-1:0] memWdata;
    logic [2:0]       opcode;

    assign opcode = ir[WIDTH-2:WIDTH-4];
    assign pcInc  = pcReg + AW'(1);

    // Architectural state register; everything changes only at the clock edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sc <= T0;       ar <= '0;     pcReg <= PC_INIT; ir <= '0;
            acReg <= '0;    dr <= '0;     tr <= '0;         eReg <= 1'b0;
            iBit <= 1'b0;   rFlag <= 1'b0; ienReg <= 1'b0;  sFlag <= 1'b1;
            fgi <= 1'b0;    fgo <= 1'b1;  inpr <= '0;       outr <= '0;
        end else begin
            sc <= scN;      ar <= arN;    pcReg <= pcN;     ir <= irN;
            acReg <= acN;   dr <= drN;    tr <= trN;        eReg <= eN;
            iBit <= iN;     rFlag <= rN;  ienReg <= ienN;   sFlag <= sN;
            fgi <= fgiN;    fgo <= fgoN;  inpr <= inprN;    outr <= outrN;
        end
    end

    // Next-state and control decode for the current timing step.
    always_comb begin
        scN = sc;  arN = ar;  pcN = pcReg;  irN = ir;  acN = acReg;  drN = dr;  trN = tr;
        eN = eReg; iN = iBit; rN = rFlag;  ienN = ienReg; sN = sFlag;
        fgiN = fgi; fgoN = fgo; inprN = inpr; outrN = outr;
        memWe = 1'b0; memWdata = '0; inpExec = 1'b0; outExec = 1'b0;

        if (!sFlag) begin
            if (start) sN = 1'b1;
        end else begin
            scN = tStep'(sc + 3'd1);
            // Interrupt request is latched only between fetch phases.
            if (ienReg && (fgi || fgo || irq) && !(sc inside {T0, T1, T2})) rN = 1'b1;
            if (rFlag) begin
                case (sc)
                    T0: begin arN = '0; trN = WIDTH'(pcReg); end
                    T1: begin memWe = 1'b1; memWdata = tr; pcN = '0; end
                    T2: begin pcN = AW'(1); ienN = 1'b0; rN = 1'b0; scN = T0; end
                    default: scN = T0;
                endcase
            end else begin
                case (sc)
                    T0: arN = pcReg;
                    T1: begin irN = bus.mem_rdata; pcN = pcInc; end
                    T2: begin arN = ir[AW-1:0]; iN = ir[WIDTH-1]; end
                    default: begin
                        if (opcode == 3'b111) begin
                            scN = T0;
                            if (!iBit) begin
                                // Register reference: highest set bit wins.
                                if      (ir[11]) acN = '0;
                                else if (ir[10]) eN = 1'b0;
                                else if (ir[9])  acN = ~acReg;
                                else if (ir[8])  eN = ~eReg;
                                else if (ir[7])  begin acN = {eReg, acReg[WIDTH-1:1]}; eN = acReg[0]; end
                                else if (ir[6])  begin acN = {acReg[WIDTH-2:0], eReg}; eN = acReg[WIDTH-1]; end
                                else if (ir[5])  acN = acReg + WIDTH'(1);
                                else if (ir[4])  begin if (!acReg[WIDTH-1]) pcN = pcInc; end
                                else if (ir[3])  begin if (acReg[WIDTH-1]) pcN = pcInc; end
                                else if (ir[2])  begin if (acReg == '0) pcN = pcInc; end
                                else if (ir[1])  begin if (!eReg) pcN = pcInc; end
                                else if (ir[0])  sN = 1'b0;
                            end else begin
                                if      (ir[11]) begin acN = {acReg[WIDTH-1:8], inpr}; inpExec = 1'b1; end
                                else if (ir[10]) begin outrN = acReg[7:0]; outExec = 1'b1; end
                                else if (ir[9])  begin if (fgi) pcN = pcInc; end
                                else if (ir[8])  begin if (fgo) pcN = pcInc; end
                                else if (ir[7])  ienN = 1'b1;
                                else if (ir[6])  ienN = 1'b0;
                            end
                        end else if (sc == T3) begin
                            if (iBit) arN = bus.mem_rdata[AW-1:0];
                        end else begin
                            scN = T0;
                            case (opcode)
                                3'd0, 3'd1, 3'd2: begin
                                    if (sc == T4) begin
                                        drN = bus.mem_rdata;
                                        scN = T5;
                                    end else if (opcode == 3'd0) acN = acReg & dr;
                                    else if (opcode == 3'd1) {eN, acN} = {1'b0, acReg} + {1'b0, dr};
                                    else acN = dr;
                                end
                                3'd3: begin memWe = 1'b1; memWdata = acReg; end
                                3'd4: pcN = ar;
                                3'd5: begin
                                    if (sc == T4) begin
                                        memWe = 1'b1; memWdata = WIDTH'(pcReg);
                                        arN = ar + AW'(1); scN = T5;
                                    end else pcN = ar;
                                end
                                default: begin
                                    if (sc == T4) begin
                                        drN = bus.mem_rdata; scN = T5;
                                    end else if (sc == T5) begin
                                        drN = dr + WIDTH'(1); scN = T6;
                                    end else begin
                                        memWe = 1'b1; memWdata = dr;
                                        if (dr == '0) pcN = pcInc;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        end

        // Device handshake flags run even while halted; the instruction side wins ties.
        if (inpExec) fgiN = 1'b0;
        else if (in_strobe && !fgi) begin fgiN = 1'b1; inprN = in_data; end
        if (outExec) fgoN = 1'b0;
        else if (out_ack && !fgo) fgoN = 1'b1;
    end

    assign bus.mem_addr  = ar;
    assign bus.mem_we    = memWe;
    assign bus.mem_wdata = memWdata;
    assign in_ready      = ~fgi;
    assign out_data      = outr;
    assign out_valid     = ~fgo;
    assign ac            = acReg;
    assign pc            = pcReg;
    assign e             = eReg;
    assign ien           = ienReg;
    assign halted        = ~sFlag;
endmodule

// File: tb/tb_bhv_basic_computer_core.sv
// Directed bench for bhv_basic_computer_core (WIDTH=16) with a bench-owned memory.
module tb_bhv_basic_computer_core;
    logic        clock = 1'b0;
    logic        reset, start, irq, in_strobe, out_ack;
    logic [7:0]  in_data, out_data;
    logic        in_ready, out_valid, e, ien, halted;
    logic [15:0] ac;
    logic [11:0] pc;
    logic [15:0] memory [0:4095];
    logic        ldEn, clr;
    logic [11:0] ldAddr;
    logic [15:0] ldData;
    int          errors = 0, checks = 0;

    bhv_basic_computer_core_if #(.WIDTH(16)) bus ();

    bhv_basic_computer_core #(.WIDTH(16), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset), .start(start), .irq(irq), .bus(bus.master),
        .in_data(in_data), .in_strobe(in_strobe), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
        .ac(ac), .pc(pc), .e(e), .ien(ien), .halted(halted)
    );

    always #5 clock = ~clock;

    assign bus.mem_rdata = memory[bus.mem_addr];

    // Memory: bench clear/load port has priority over core writes.
    always @(posedge clock) begin
        if (clr) begin
            for (int k = 0; k < 4096; k++) memory[k] <= '0;
        end else if (ldEn) memory[ldAddr] <= ldData;
        else if (bus.mem_we) memory[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic run(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        ldAddr = a; ldData = d; ldEn = 1'b1;
        @(posedge clock); #1;
        ldEn = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1; clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        start = 1'b1;
        run(2);
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h want 000", pc); end
        checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL reset_ac: got %h want 0000", ac); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
        checks++; if ({e, ien} !== 2'b00) begin errors++; $display("FAIL reset_e_ien: got %b want 00", {e, ien}); end
        start = 1'b0;
    endtask

    task automatic test_add_program();
        doReset();
        poke(12'h000, 16'h2004); poke(12'h001, 16'h1005); poke(12'h002, 16'h3006);
        poke(12'h003, 16'h7001); poke(12'h004, 16'h7FFF); poke(12'h005, 16'h0002);
        release_reset();
        run(20);
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL add_early_halt: got %b want 0", halted); end
        run(1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL add_halted: got %b want 1", halted); end
        checks++; if (ac !== 16'h8001) begin errors++; $display("FAIL add_ac: got %h want 8001", ac); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_e: got %b want 0", e); end
        checks++; if (memory[6] !== 16'h8001) begin errors++; $display("FAIL add_sta: got %h want 8001", memory[6]); end
        run(3);
        checks++; if (pc !== 12'h004) begin errors++; $display("FAIL halt_frozen_pc: got %h want 004", pc); end
        // Resume: M[4]=7FFF decodes as CLA (highest bit wins).
        start = 1'b1; run(1); start = 1'b0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL start_resume: got %b want 0", halted); end
        run(4);
        checks++; if ({ac, pc} !== {16'h0000, 12'h005}) begin errors++; $display("FAIL start_cla: got %h want 0000005", {ac, pc}); end
    endtask

    task automatic test_indirect();
        doReset();
        poke(12'h000, 16'hA007); poke(12'h001, 16'h1005); poke(12'h002, 16'h3006);
        poke(12'h003, 16'h7001); poke(12'h004, 16'hFFFF); poke(12'h005, 16'h0001);
        poke(12'h007, 16'h0004);
        release_reset();
        run(21);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ind_halted: got %b want 1", halted); end
        checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL ind_ac: got %h want 0000", ac); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL ind_carry: got %b want 1", e); end
        checks++; if (memory[6] !== 16'h0000) begin errors++; $display("FAIL ind_sta: got %h want 0000", memory[6]); end
    endtask

    task automatic test_isz();
        doReset();
        poke(12'h000, 16'h6008); poke(12'h001, 16'h7001); poke(12'h002, 16'h7001);
        poke(12'h008, 16'hFFFF);
        release_reset();
        run(11);
        checks++; if (memory[8] !== 16'h0000) begin errors++; $display("FAIL isz_mem: got %h want 0000", memory[8]); end
        checks++; if (pc !== 12'h003) begin errors++; $display("FAIL isz_skip_pc: got %h want 003", pc); end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL isz_halted: got %b want 1", halted); end
    endtask

    task automatic test_bsa();
        doReset();
        poke(12'h000, 16'h4020); poke(12'h020, 16'h5010);
        release_reset();
        run(5);
        checks++; if (pc !== 12'h020) begin errors++; $display("FAIL bun_pc: got %h want 020", pc); end
        run(6);
        checks++; if (memory[16] !== 16'h0021) begin errors++; $display("FAIL bsa_ret: got %h want 0021", memory[16]); end
        checks++; if (pc !== 12'h011) begin errors++; $display("FAIL bsa_pc: got %h want 011", pc); end
    endtask

    task automatic test_regref();
        logic [15:0] prog [0:11];
        prog = '{16'h7800, 16'h7200, 16'h7020, 16'h7004, 16'h7001, 16'h7100,
                 16'h7040, 16'h7080, 16'h7010, 16'h7001, 16'h7002, 16'h7001};
        doReset();
        for (int k = 0; k < 12; k++) poke(12'(k), prog[k]);
        release_reset();
        run(40);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL reg_halted: got %b want 1", halted); end
        checks++; if (pc !== 12'h00C) begin errors++; $display("FAIL reg_pc: got %h want 00c", pc); end
        checks++; if (ac !== 16'h0000) begin errors++; $display("FAIL reg_ac: got %h want 0000", ac); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL reg_e: got %b want 1", e); end
    endtask

    task automatic test_io();
        doReset();
        poke(12'h000, 16'hF800); poke(12'h001, 16'hF400); poke(12'h002, 16'hF100);
        poke(12'h003, 16'h7001);
        release_reset();
        in_strobe = 1'b1; in_data = 8'h5A;
        run(1);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL io_fgi_set: got %b want 0", in_ready); end
        in_data = 8'h77;
        run(1);
        in_strobe = 1'b0;
        run(14);
        checks++; if (ac !== 16'h005A) begin errors++; $display("FAIL io_inp_ac: got %h want 005a", ac); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL io_inp_clear: got %b want 1", in_ready); end
        checks++; if ({out_valid, out_data} !== 9'h15A) begin errors++; $display("FAIL io_out: got %h want 15a", {out_valid, out_data}); end
        checks++; if (pc !== 12'h004) begin errors++; $display("FAIL io_sko_pc: got %h want 004", pc); end
        out_ack = 1'b1; run(1); out_ack = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL io_ack: got %b want 0", out_valid); end
    endtask

    task automatic test_interrupt();
        doReset();
        poke(12'h000, 16'h4010); poke(12'h001, 16'hF800); poke(12'h002, 16'h7001);
        poke(12'h010, 16'hF080); poke(12'h011, 16'h7800);
        release_reset();
        in_strobe = 1'b1; in_data = 8'h41;
        run(1);
        in_strobe = 1'b0;
        for (int k = 0; k < 80 && halted !== 1'b1; k++) run(1);
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL int_timeout: got halted=%b want 1", halted); end
        checks++; if (memory[0] !== 16'h0012) begin errors++; $display("FAIL int_ret: got %h want 0012", memory[0]); end
        checks++; if (ien !== 1'b0) begin errors++; $display("FAIL int_ien: got %b want 0", ien); end
        checks++; if (ac !== 16'h0041) begin errors++; $display("FAIL int_ac: got %h want 0041", ac); end
        checks++; if ({in_ready, pc} !== {1'b1, 12'h003}) begin errors++; $display("FAIL int_fgi_pc: got %h want 1003", {in_ready, pc}); end
    endtask

    task automatic test_reset_mid();
        logic weSeen;
        doReset();
        poke(12'h000, 16'h6008); poke(12'h008, 16'hFFFF);
        release_reset();
        run(5);
        reset = 1'b1;
        weSeen = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus.mem_we !== 1'b0) weSeen = 1'b1;
        end
        #1;
        checks++; if (weSeen !== 1'b0) begin errors++; $display("FAIL mid_we: got %b want 0", weSeen); end
        checks++; if (memory[8] !== 16'hFFFF) begin errors++; $display("FAIL mid_mem: got %h want ffff", memory[8]); end
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL mid_pc: got %h want 000", pc); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_fgo: got %b want 0", out_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted: got %b want 0", halted); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; irq = 1'b0; in_strobe = 1'b0; out_ack = 1'b0;
        in_data = 8'h00; ldEn = 1'b0; clr = 1'b0; ldAddr = '0; ldData = '0;
        test_reset();
        test_add_program();
        test_indirect();
        test_isz();
        test_bsa();
        test_regref();
        test_io();
        test_interrupt();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
